alu_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the register-file / shifter / ALU datapath for one instruction at a time.
- Decodes opcode/op latched from the instruction register and drives register-file selects, pipeline-register loads, operand muxes, the ALU-op pass-through, status load and write-back.
- Sits between the instruction register and the datapath. Also keeps a count of retired instructions.

---
 rtl/alu_sequencer.sv | 114 +++++++++++
 tb/tb_alu_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle Moore FSM sequencing the register-file/shifter/ALU datapath,
// one instruction at a time, with a retired-instruction counter.
module alu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [2:0]       opcode,
  input  logic [1:0]       op,
  output logic             w,
  output logic [2:0]       nsel,
  output logic [1:0]       vsel,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       ALUop,
  output logic             err,
  output logic [CNT_W-1:0] icount
);
  typedef enum logic [2:0] {WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG, ILLEGAL} state_t;
  state_t state_q, state_d;
  logic [2:0] opcode_q, opcode_d;
  logic [1:0] op_q, op_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic is_mov, is_cmp, is_alu;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= WAIT;
      opcode_q <= '0;
      op_q     <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_q     <= op_d;
      icount_q <= icount_d;
    end
  always_comb begin
    is_mov   = opcode_q == 3'b110;
    is_alu   = opcode_q == 3'b101;
    is_cmp   = is_alu && op_q == 2'b01;
    state_d  = state_q;
    opcode_d = opcode_q;
    op_d     = op_q;
    icount_d = icount_q;
    w        = 1'b0;
    nsel     = 3'b000;
    vsel     = 2'b00;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    err      = 1'b0;
    case (state_q)
      WAIT: begin
        w = 1'b1;
        if (s) begin
          state_d  = DECODE;
          opcode_d = opcode;
          op_d     = op;
        end
      end
      DECODE:
        // MOV reg and MVN need only the Rm operand, so they skip GET_A
        state_d = (is_mov && op_q == 2'b10) ? WRITE_IMM :
                  ((is_mov && op_q == 2'b00) || (is_alu && op_q == 2'b11)) ? GET_B :
                  is_alu ? GET_A : ILLEGAL;
      WRITE_IMM: begin
        nsel     = 3'b001;
        vsel     = 2'b10;
        write    = 1'b1;
        state_d  = WAIT;
        icount_d = icount_q + CNT_W'(1);
      end
      GET_A: begin
        nsel    = 3'b001;
        loada   = 1'b1;
        state_d = GET_B;
      end
      GET_B: begin
        nsel    = 3'b100;
        loadb   = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        asel     = is_mov;
        loads    = is_cmp;
        loadc    = !is_cmp;
        state_d  = is_cmp ? WAIT : WRITE_REG;
        icount_d = is_cmp ? icount_q + CNT_W'(1) : icount_q;
      end
      WRITE_REG: begin
        nsel     = 3'b010;
        write    = 1'b1;
        state_d  = WAIT;
        icount_d = icount_q + CNT_W'(1);
      end
      default: begin
        err     = 1'b1;
        state_d = WAIT;
      end
    endcase
  end
  assign ALUop  = op_q;
  assign icount = icount_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized instruction streams checked cycle by cycle
// against per-instruction expected control-word sequences built from the instruction set.
module tb_alu_sequencer;
  logic clk, reset, s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic w, write, loada, loadb, loadc, loads, asel, bsel, err;
  logic [2:0] nsel;
  logic [1:0] vsel, ALUop;
  logic [3:0] icount;
  int total = 0;
  int bad = 0;
  logic [3:0] cnt = '0;

  alu_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .err(err), .icount(icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cw(input logic wi, input logic [2:0] ns, input logic [1:0] vs,
                                     input logic wr, la, lb, lc, ls, as, input logic [1:0] al,
                                     input logic er);
    return {wi, ns, vs, wr, la, lb, lc, ls, as, 1'b0, al, er};
  endfunction

  function automatic logic [15:0] obs();
    return {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, ALUop, err};
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge of the next idle cycle.
  task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] o, input bit keep_s);
    logic [15:0] exp_q[$];
    bit mov_imm, mov_reg, mvn, cmp, retire;
    mov_imm = opc == 3'd6 && o == 2'd2;
    mov_reg = opc == 3'd6 && o == 2'd0;
    mvn     = opc == 3'd5 && o == 2'd3;
    cmp     = opc == 3'd5 && o == 2'd1;
    retire  = mov_imm || mov_reg || opc == 3'd5;
    exp_q.push_back(cw(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, o, 0));
    if (mov_imm)
      exp_q.push_back(cw(0, 3'b001, 2'b10, 1, 0, 0, 0, 0, 0, o, 0));
    else if (retire) begin
      if (!(mov_reg || mvn)) exp_q.push_back(cw(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0, o, 0));
      exp_q.push_back(cw(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, o, 0));
      exp_q.push_back(cw(0, 3'b000, 2'b00, 0, 0, 0, !cmp, cmp, mov_reg, o, 0));
      if (!cmp) exp_q.push_back(cw(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, o, 0));
    end else
      exp_q.push_back(cw(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, o, 1));
    exp_q.push_back(cw(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, o, 0));
    chk({name, " idle"}, {31'd0, w}, 32'd1);
    opcode = opc;
    op = o;
    s = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_s) begin
      opcode = 3'($urandom);
      op = ~o;
      s = 1'($urandom);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d ctl", name, i + 1), {16'd0, obs()}, {16'd0, exp_q[i]});
      chk($sformatf("%s c%0d icount", name, i + 1), {28'd0, icount},
          {28'd0, (i == exp_q.size() - 1) ? cnt + 4'(retire) : cnt});
    end
    cnt = cnt + 4'(retire);
    if (!keep_s) s = 1'b0;
  endtask

  initial begin
    logic [2:0] lo [6];
    logic [1:0] lp [6];
    lo = '{3'd6, 3'd6, 3'd5, 3'd5, 3'd5, 3'd5};
    lp = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    reset = 1'b0;
    s = 1'b0;
    opcode = 3'd0;
    op = 2'd0;
    repeat (2) @(negedge clk);
    chk("reset ctl", {16'd0, obs()}, {16'd0, cw(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0)});
    chk("reset icount", {28'd0, icount}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    run_instr("mov_imm", 3'd6, 2'd2, 0);
    opcode = 3'd5;
    op = 2'd0;
    s = 1'b1;
    repeat (3) @(posedge clk);
    #1 s = 1'b0;
    chk("pre_rst loadb", {31'd0, loadb}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid w", {31'd0, w}, 32'd1);
    chk("rst_mid loadb", {31'd0, loadb}, 32'd0);
    chk("rst_mid icount", {28'd0, icount}, 32'd0);
    chk("rst_mid aluop", {30'd0, ALUop}, 32'd0);
    cnt = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_instr("add", 3'd5, 2'd0, 0);
    run_instr("cmp", 3'd5, 2'd1, 0);
    run_instr("mvn", 3'd5, 2'd3, 0);
    run_instr("and", 3'd5, 2'd2, 0);
    run_instr("mov_reg", 3'd6, 2'd0, 0);
    run_instr("illegal", 3'd7, 2'd0, 0);
    run_instr("illegal110", 3'd6, 2'd1, 0);
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1)
        run_instr($sformatf("rnd%0d", i), lo[k], lp[k], $urandom_range(0, 3) == 0);
      else
        run_instr($sformatf("rnd%0d", i), 3'($urandom), 2'($urandom), $urandom_range(0, 3) == 0);
    end
    s = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cnt = '0;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) run_instr($sformatf("wrap%0d", i), 3'd6, 2'd2, 1);
    chk("wrap end icount", {28'd0, icount}, 32'd1);
    s = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
